// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the 8-bit CPU: FETCH/DECODE/EXEC/MEM/WB sequencer
// with Moore datapath controls, data-memory wait/timeout handling and a retire counter.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       Clk,
  input  logic       Clear,
  input  logic [7:0] Instruction,
  input  logic       Mem_Ready,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic [2:0] State,
  output logic       Retired,
  output logic [7:0] Instr_Count,
  output logic       Fault
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  logic [2:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] count_q, count_d;
  logic       fault_q, fault_d;

  logic       in_mem;
  logic       mem_timeout;
  logic       retire;

  // Memory handshake: MemRead/MemWrite is the request and stays asserted every
  // MEM cycle; Mem_Ready is the completion and is only observed while in MEM.
  // Completion on the same cycle the wait counter hits its limit wins over timeout.
  assign in_mem      = (state_q == S_MEM);
  assign mem_timeout = in_mem && !Mem_Ready && (wait_q == WAIT_MAX);

  // The IR is written at the end of FETCH, so the opcode is first valid in DECODE.
  always_comb begin
    op_d = op_q;
    if (state_q == S_DECODE) begin
      op_d = Instruction[7:6];
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op_q)
          OP_ADD:       state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (Mem_Ready) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (mem_timeout) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Counter is zero on every MEM entry because it only survives consecutive stalls.
  always_comb begin
    wait_d = 8'd0;
    if (in_mem && !Mem_Ready) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_EXEC:  retire = (op_q == OP_J);
      S_MEM:   retire = (op_q == OP_SW) && Mem_Ready;
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (retire) begin
      count_d = count_q + 8'd1;
    end
  end

  always_comb begin
    fault_d = fault_q | mem_timeout;
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state_q <= S_FETCH;
      op_q    <= OP_ADD;
      wait_q  <= 8'd0;
      count_q <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrc = (op_q == OP_LW) || (op_q == OP_SW);
        if (op_q == OP_J) begin
          PCWrite = 1'b1;
          PCSrc   = 1'b1;
        end
      end
      S_MEM: begin
        ALUSrc   = 1'b1;
        MemRead  = (op_q == OP_LW);
        MemWrite = (op_q == OP_SW);
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = (op_q == OP_ADD);
        MemtoReg = (op_q == OP_LW);
      end
      default: ;
    endcase
  end

  assign State       = state_q;
  assign Retired     = retire;
  assign Instr_Count = count_q;
  assign Fault       = fault_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds each instruction's expected phase trace from
// its opcode and stall count, then checks every cycle's outputs against it.
module tb_multicycle_ctrl;

  localparam int MEM_WAIT_MAX = 15;

  // Phase numbers equal the documented debug encodings of State.
  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_EXEC   = 2;
  localparam int P_MEM    = 3;
  localparam int P_WB     = 4;

  logic       clk;
  logic       clear;
  logic [7:0] instruction;
  logic       mem_ready;
  logic       ir_write, pc_write, pc_src, reg_dst, reg_write, alu_src;
  logic       mem_read, mem_write, mem_to_reg, retired, fault;
  logic [2:0] state;
  logic [7:0] instr_count;

  int n_checks;
  int n_errors;
  int exp_count;
  bit exp_fault;

  multicycle_ctrl #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .Clk        (clk),
    .Clear      (clear),
    .Instruction(instruction),
    .Mem_Ready  (mem_ready),
    .IRWrite    (ir_write),
    .PCWrite    (pc_write),
    .PCSrc      (pc_src),
    .RegDst     (reg_dst),
    .RegWrite   (reg_write),
    .ALUSrc     (alu_src),
    .MemRead    (mem_read),
    .MemWrite   (mem_write),
    .MemtoReg   (mem_to_reg),
    .State      (state),
    .Retired    (retired),
    .Instr_Count(instr_count),
    .Fault      (fault)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one instruction cycle by cycle from its FETCH cycle. stalls is the number
  // of Mem_Ready=0 MEM cycles before completion (beyond the limit means timeout).
  // abort_mem >= 0 asserts Clear in that MEM cycle and abandons the instruction.
  task automatic run_instr(input logic [7:0] instr, input int stalls, input int abort_mem);
    logic [1:0] op;
    int ph_q[$];
    int mem_k;
    bit timeout;
    bit ready;
    logic [9:0] exp_ctl;
    logic [9:0] got_ctl;
    bit       e_ir, e_pcw, e_pcs, e_rd, e_rw, e_alu, e_mr, e_mw, e_m2r, e_ret;
    op = instr[7:6];
    timeout = 1'b0;
    ph_q = {P_FETCH, P_DECODE, P_EXEC};
    if (op == 2'b00) begin
      ph_q.push_back(P_WB);
    end else if (op != 2'b11) begin
      timeout = (stalls > MEM_WAIT_MAX);
      for (int k = 0; k < (timeout ? MEM_WAIT_MAX + 1 : stalls + 1); k++) ph_q.push_back(P_MEM);
      if (op == 2'b01 && !timeout) ph_q.push_back(P_WB);
    end
    mem_k = 0;
    for (int c = 0; c < ph_q.size(); c++) begin
      @(negedge clk);
      instruction = (c == 0) ? 8'($urandom) : instr;
      ready = (ph_q[c] == P_MEM) ? (mem_k == stalls) : 1'($urandom_range(0, 1));
      mem_ready = ready;
      clear = (ph_q[c] == P_MEM) && (mem_k == abort_mem);
      {e_ir, e_pcw, e_pcs, e_rd, e_rw, e_alu, e_mr, e_mw, e_m2r, e_ret} = '0;
      case (ph_q[c])
        P_FETCH: begin e_ir = 1; e_pcw = 1; end
        P_EXEC: begin
          e_alu = (op == 2'b01) || (op == 2'b10);
          if (op == 2'b11) begin e_pcw = 1; e_pcs = 1; e_ret = 1; end
        end
        P_MEM: begin
          e_alu = 1;
          e_mr  = (op == 2'b01);
          e_mw  = (op == 2'b10);
          e_ret = (op == 2'b10) && ready;
        end
        P_WB: begin
          e_rw = 1; e_ret = 1;
          e_rd = (op == 2'b00);
          e_m2r = (op == 2'b01);
        end
        default: ;
      endcase
      exp_ctl = {e_ir, e_pcw, e_pcs, e_rd, e_rw, e_alu, e_mr, e_mw, e_m2r, e_ret};
      #2;
      got_ctl = {ir_write, pc_write, pc_src, reg_dst, reg_write, alu_src,
                 mem_read, mem_write, mem_to_reg, retired};
      check_eq("state", 16'(state), 16'(ph_q[c]));
      check_eq("controls", 16'(got_ctl), 16'(exp_ctl));
      check_eq("instr_count", 16'(instr_count), 16'(exp_count));
      check_eq("fault", 16'(fault), 16'(exp_fault));
      check_eq("mem_excl", 16'(mem_read & mem_write), 16'd0);
      if (clear) begin
        exp_count = 0;
        exp_fault = 1'b0;
        return;
      end
      if (e_ret) exp_count = (exp_count + 1) % 256;
      if (ph_q[c] == P_MEM && timeout && mem_k == MEM_WAIT_MAX) exp_fault = 1'b1;
      if (ph_q[c] == P_MEM) mem_k++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_count = 0;
    exp_fault = 1'b0;
    instruction = 8'h00;
    mem_ready = 1'b0;
    clear = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check_eq("reset_state", 16'(state), 16'd0);
    check_eq("reset_count", 16'(instr_count), 16'd0);
    check_eq("reset_fault", 16'(fault), 16'd0);

    run_instr(8'b00_01_10_11, 0, -1);             // add
    run_instr(8'b01_00_10_01, 3, -1);             // lw with 3 stalls
    run_instr(8'b10_11_00_10, 99, -1);            // sw timeout
    run_instr(8'b11_101010, 0, -1);               // j
    run_instr(8'b01_10_01_11, MEM_WAIT_MAX, -1);  // ready on the limit cycle
    run_instr(8'b10_01_01_01, MEM_WAIT_MAX, -1);
    for (int i = 0; i < 256; i++) run_instr({2'b00, 6'($urandom)}, 0, -1);
    for (int i = 0; i < 60; i++) begin
      run_instr(8'($urandom), ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(0, 15), -1);
    end
    run_instr(8'b01_00_10_01, 5, 2);              // Clear during lw MEM
    run_instr(8'b00_11_01_10, 0, -1);
    for (int i = 0; i < 10; i++) run_instr(8'($urandom), $urandom_range(0, 4), -1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
